reg_scan_reader: RTL
====================

REG_SCAN_READER -- requirements
Module: reg_scan_reader

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a scan; sampled only in IDLE.
REQ-006 first_reg  input  ADDR_W  first index to read; captured on accepted start.
REQ-007 last_reg  input  ADDR_W  last index to read; captured on accepted start.
REQ-008 rd_addr  output  ADDR_W  register-file read address; drives the combinational read port.
REQ-009 rd_data  input  DATA_W  register-file read data, valid in the same cycle as rd_addr.
REQ-010 out_valid  output  1  out_data/out_index/out_last hold a beat.
REQ-011 out_ready  input  1  sink accepts the beat when out_valid and out_ready are both high.
REQ-012 out_data  output  DATA_W  register contents.
REQ-013 out_index  output  ADDR_W  index that out_data was read from.
REQ-014 out_last  output  1  beat is the final one of the scan.
REQ-015 busy  output  1  high in SCAN.
REQ-016 done  output  1  one-cycle pulse after the final beat is accepted.
REQ-017 checksum  output  DATA_W  XOR of all accepted beats of the current or last scan.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-019 In IDLE, start=1 SHALL capture first_reg/last_reg, load the pointer with first_reg, clear checksum and enter SCAN next cycle.
REQ-020 The beat count SHALL be ((last_reg - first_reg) mod 2^ADDR_W) + 1: 1..32 beats, with first_reg > last_reg wrapping from 31 to 0.
REQ-021 rd_addr SHALL equal the pointer in every state; it idles at the last captured value.
REQ-022 In SCAN, when the output slot is empty or is being accepted this cycle, the block SHALL load rd_data, the pointer index and the last flag into the output registers, set out_valid and advance the pointer modulo 2^ADDR_W.
REQ-023 The first out_valid SHALL assert exactly 2 cycles after the start cycle.
REQ-024 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL remain stable.
REQ-026 No new read SHALL be issued after the out_last beat has been loaded.
REQ-027 checksum SHALL XOR in out_data on each accepted beat.
REQ-028 Acceptance of the out_last beat SHALL clear out_valid and move the FSM to DONE.
REQ-029 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-030 start in SCAN or DONE SHALL be ignored, not queued.
REQ-031 Register-file contents that change during a scan SHALL be reported as read at the cycle they were sampled; no coherence is guaranteed.

Reset
REQ-032 reset SHALL force IDLE, pointer=0, captured bounds=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0 and checksum=0.
REQ-033 reset SHALL take priority over start and handshakes, and SHALL abort a scan in progress with no done pulse.

Structure
REQ-034 The state enum and default widths SHALL live in the shared package cpu_pkg.
REQ-035 The output slot SHALL be one sub-module, out_slot (single-entry valid/ready register).
REQ-036 The block SHALL be purely synchronous with no latches.

Verification
REQ-037 Regfile preloaded with R[i]=i*0x11; first=0, last=31, out_ready=1 -> 32 beats on consecutive cycles, index 0..31, out_last on index 31, done pulse, checksum = XOR of all values.
REQ-038 first=30, last=1 -> 4 beats, index order 30, 31, 0, 1, out_last on index 1.
REQ-039 first=last=5 with R5=0xDEADBEEF -> 1 beat with out_last=1, checksum=0xDEADBEEF.
REQ-040 out_ready toggling 1,0,0,1 per cycle over a 0..7 scan -> no beat lost or duplicated, payload stable while stalled.
REQ-041 start pulsed during SCAN -> ignored, current scan completes unchanged.
REQ-042 reset asserted mid-scan at beat 3 -> next cycle out_valid=0, busy=0, checksum=0, no done pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the register-scan reader.
package cpu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/reg_scan_reader_out_slot.sv
// Single-entry valid/ready output register holding one scan beat.
module out_slot
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_index,
  input  logic              in_last,
  output logic              can_load,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q,  last_d;

  // A full slot can be refilled in the same cycle its beat is accepted.
  assign can_load = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      index_d = in_index;
      last_d  = in_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;

endmodule

// File: rtl/reg_scan_reader.sv
// Streams a wrapping range of register-file entries out over valid/ready,
// accumulating an XOR checksum of every accepted beat.
module reg_scan_reader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [ADDR_W-1:0] last_q,  last_d;
  logic              issued_q, issued_d;
  logic [DATA_W-1:0] csum_q,  csum_d;

  logic slot_load;
  logic slot_can_load;
  logic accept;

  assign accept = out_valid && out_ready;

  // Every index in a scan is visited at most once, so matching the captured
  // last index marks the final beat even for a full 32-entry wrap.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    issued_d  = issued_q;
    csum_d    = csum_q;
    slot_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d    = first_reg;
          last_d   = last_reg;
          issued_d = 1'b0;
          csum_d   = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!issued_q && slot_can_load) begin
          slot_load = 1'b1;
          ptr_d     = ptr_q + ADDR_W'(1);
          if (ptr_q == last_q) issued_d = 1'b1;
        end
        if (accept) begin
          csum_d = csum_q ^ out_data;
          if (out_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      last_q   <= '0;
      issued_q <= 1'b0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      issued_q <= issued_d;
      csum_q   <= csum_d;
    end
  end

  out_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (slot_load),
    .in_data   (rd_data),
    .in_index  (ptr_q),
    .in_last   (ptr_q == last_q),
    .can_load  (slot_can_load),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  assign rd_addr  = ptr_q;
  assign busy     = (state_q == ST_SCAN);
  assign done     = (state_q == ST_DONE);
  assign checksum = csum_q;

endmodule
